flash_block_streamer: RTL and testbench
=======================================

FLASH_BLOCK_STREAMER -- requirements
Module: flash_block_streamer

Interface
REQ-001 Parameter BLOCK_SIZE, default 512, bytes per flash block; legal values 1..512.
REQ-002 i_clk  in  1  system clock; all logic on its rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_start  in  1  one-cycle strobe; begin a multi-block read.
REQ-005 i_start_addr  in  24  byte address of first block; sampled with i_start.
REQ-006 i_num_blocks  in  16  number of blocks to fetch; sampled with i_start.
REQ-007 o_busy  out  1  high from the cycle after an accepted i_start until o_done_stb.
REQ-008 o_done_stb  out  1  one-cycle strobe; all requested bytes delivered.
REQ-009 o_read_addr  out  24  block start address to the flash controller.
REQ-010 o_read_stb  out  1  one-cycle read request to the flash controller.
REQ-011 i_read_done_stb  in  1  flash controller block-complete strobe.
REQ-012 i_write_bram_stb  in  1  flash controller byte-valid strobe.
REQ-013 i_read_bram_addr  in  10  byte offset within the block.
REQ-014 i_read_bram_data  in  8  byte data.
REQ-015 o_data  out  8  stream byte.
REQ-016 o_valid  out  1  stream valid.
REQ-017 i_ready  in  1  stream ready from the consumer.
REQ-018 o_block_last  out  1  marks the last byte of each block.
REQ-019 o_last  out  1  marks the last byte of the whole transfer.

Function
REQ-020 Storage SHALL be two BLOCK_SIZE-byte buffers (ping-pong), each with a full flag; fill select and drain select each start at buffer 0.
REQ-021 Request FSM states SHALL be S_IDLE, S_REQ, S_WAIT and S_DRAIN.
REQ-022 In S_IDLE, i_start SHALL latch the inputs, clear the block counter and go to S_REQ; with i_num_blocks==0 it SHALL instead pulse o_done_stb the next cycle and stay in S_IDLE.
REQ-023 In S_REQ, when the fill-select buffer is not full, the block SHALL pulse o_read_stb for one cycle with o_read_addr = start_addr + n*BLOCK_SIZE (mod 2^24, wraps) and go to S_WAIT.
REQ-024 In S_WAIT, i_write_bram_stb SHALL write i_read_bram_data at i_read_bram_addr into the fill buffer; writes with an address >= BLOCK_SIZE SHALL be dropped.
REQ-025 In S_WAIT, i_read_done_stb SHALL set the fill buffer's full flag, toggle the fill select and increment n; the FSM then goes to S_DRAIN if n==num_blocks, else to S_REQ.
REQ-026 Byte and done strobes received in any state other than S_WAIT SHALL be ignored.
REQ-027 The drain side SHALL stream a full buffer's bytes at offsets 0..BLOCK_SIZE-1 in order; the buffer read SHALL be synchronous, feeding an output register.
REQ-028 o_valid SHALL assert 2 cycles after the cycle that sets a full flag, when the drain side is idle on that buffer.
REQ-029 Stream handshake: a transfer occurs when o_valid && i_ready.
  - o_data, o_block_last and o_last SHALL hold stable while o_valid && !i_ready.
  - o_valid SHALL never deassert without a transfer.
REQ-030 Back-to-back transfers SHALL sustain 1 byte/cycle within a block and across a ping-pong switch when the next buffer is already full.
REQ-031 A transfer of offset BLOCK_SIZE-1 SHALL assert o_block_last, clear that buffer's full flag (visible to S_REQ next cycle) and toggle the drain select.
REQ-032 o_last SHALL accompany o_block_last of block num_blocks-1.
REQ-033 In S_DRAIN, the cycle after the o_last transfer SHALL pulse o_done_stb, drop o_busy and enter S_IDLE.
REQ-034 i_start while o_busy SHALL be ignored.
REQ-035 Simultaneous fill completion on one buffer and drain completion on the other SHALL both take effect in the same cycle.
REQ-036 The integrator SHALL issue i_start only while the flash controller is idle.

Reset
REQ-037 While i_rst_n is low, these SHALL be 0: o_busy, o_done_stb, o_read_stb, o_read_addr, o_valid, o_data, o_block_last, o_last, the full flags, both selects, the counters; the FSM SHALL be in S_IDLE.
REQ-038 Reset mid-transfer SHALL discard buffered data; a late i_read_done_stb after reset SHALL be ignored (S_IDLE).

Verification
REQ-039 Start addr 0x000100, 1 block, i_ready=1 -> one o_read_stb with addr 0x000100; 512 bytes in order; o_block_last=o_last on byte 511; o_done_stb next cycle.
REQ-040 3 blocks from 0xFFFE00 -> read addresses 0xFFFE00, 0x000000, 0x000200; 1536 bytes; o_last only on the final byte.
REQ-041 i_ready held 0 after 2 blocks filled -> no third o_read_stb until a buffer drains; o_data stable while stalled.
REQ-042 i_num_blocks=0 -> o_done_stb the cycle after i_start; no o_read_stb.
REQ-043 i_rst_n pulsed low mid-block, then stale i_read_done_stb -> all outputs 0 and no o_valid.
REQ-044 Random i_ready with back-pressure over 4 blocks -> byte stream matches the flash model; no drops or duplicates.

Source files
------------

// File: rtl/flash_block_streamer.sv
// Multi-block flash reader: requests BLOCK_SIZE-byte blocks from a flash controller into
// ping-pong buffers and streams the buffered bytes out over a valid/ready byte interface.
module flash_block_streamer #(
  parameter int BLOCK_SIZE = 512
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_start_addr,
  input  logic [15:0] i_num_blocks,
  output logic        o_busy,
  output logic        o_done_stb,
  output logic [23:0] o_read_addr,
  output logic        o_read_stb,
  input  logic        i_read_done_stb,
  input  logic        i_write_bram_stb,
  input  logic [9:0]  i_read_bram_addr,
  input  logic [7:0]  i_read_bram_data,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_block_last,
  output logic        o_last,
  output logic [1:0]  o_dbg_state
);

  localparam int          AW        = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [9:0]  LAST_OFF  = 10'(BLOCK_SIZE - 1);
  localparam logic [9:0]  SIZE_OFF  = 10'(BLOCK_SIZE);
  localparam logic [23:0] ADDR_STEP = 24'(BLOCK_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nxt;
  logic [23:0] req_addr;
  logic [15:0] num_blocks, req_cnt, fetch_blk;
  logic        fill_sel, drain_sel, fetch_sel;
  logic [1:0]  full;
  logic [9:0]  fetch_off;
  logic [7:0]  mem0 [BLOCK_SIZE];
  logic [7:0]  mem1 [BLOCK_SIZE];

  logic start_acc, issue_req, fill_done, byte_wr;
  logic xfer, xfer_block_end, load, fetch_end;
  logic [7:0] rd_byte;

  // Stream handshake: a byte moves when o_valid && i_ready; while o_valid && !i_ready
  // the output register (o_data/o_block_last/o_last) holds and o_valid stays high.
  assign start_acc      = (state == S_IDLE) && i_start;
  assign issue_req      = (state == S_REQ) && !full[fill_sel];
  assign fill_done      = (state == S_WAIT) && i_read_done_stb;
  assign byte_wr        = (state == S_WAIT) && i_write_bram_stb && (i_read_bram_addr < SIZE_OFF);
  assign xfer           = o_valid && i_ready;
  assign xfer_block_end = xfer && o_block_last;
  assign load           = full[fetch_sel] && (!o_valid || i_ready);
  assign fetch_end      = (fetch_off == LAST_OFF);
  assign rd_byte        = fetch_sel ? mem1[fetch_off[AW-1:0]] : mem0[fetch_off[AW-1:0]];
  assign o_dbg_state    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start && i_num_blocks != 16'd0) state_nxt = S_REQ;
      S_REQ:   if (!full[fill_sel]) state_nxt = S_WAIT;
      S_WAIT:  if (i_read_done_stb)
                 state_nxt = (req_cnt + 16'd1 == num_blocks) ? S_DRAIN : S_REQ;
      S_DRAIN: if (xfer && o_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer contents are not reset; clearing the full flags discards them.
  always_ff @(posedge i_clk) begin
    if (byte_wr) begin
      if (fill_sel) mem1[i_read_bram_addr[AW-1:0]] <= i_read_bram_data;
      else          mem0[i_read_bram_addr[AW-1:0]] <= i_read_bram_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      req_addr     <= '0;
      num_blocks   <= '0;
      req_cnt      <= '0;
      fetch_blk    <= '0;
      fill_sel     <= 1'b0;
      drain_sel    <= 1'b0;
      fetch_sel    <= 1'b0;
      full         <= '0;
      fetch_off    <= '0;
      o_busy       <= 1'b0;
      o_done_stb   <= 1'b0;
      o_read_stb   <= 1'b0;
      o_read_addr  <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_block_last <= 1'b0;
      o_last       <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_done_stb <= 1'b0;
      o_read_stb <= 1'b0;

      if (start_acc) begin
        num_blocks <= i_num_blocks;
        req_addr   <= i_start_addr;
        req_cnt    <= '0;
        fetch_blk  <= '0;
        if (i_num_blocks == 16'd0) o_done_stb <= 1'b1;
        else                       o_busy     <= 1'b1;
      end

      if (issue_req) begin
        o_read_stb  <= 1'b1;
        o_read_addr <= req_addr;
        req_addr    <= req_addr + ADDR_STEP;
      end

      // Fill and drain always touch different buffers, so both updates can land together.
      if (fill_done) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= ~fill_sel;
        req_cnt        <= req_cnt + 16'd1;
      end
      if (xfer_block_end) begin
        full[drain_sel] <= 1'b0;
        drain_sel       <= ~drain_sel;
      end

      if (state == S_DRAIN && xfer && o_last) begin
        o_done_stb <= 1'b1;
        o_busy     <= 1'b0;
      end

      // Fetch runs one byte ahead of the consumer and hops to the other buffer at block end.
      if (load) begin
        o_valid      <= 1'b1;
        o_data       <= rd_byte;
        o_block_last <= fetch_end;
        o_last       <= fetch_end && (fetch_blk == num_blocks - 16'd1);
        if (fetch_end) begin
          fetch_off <= '0;
          fetch_sel <= ~fetch_sel;
          fetch_blk <= fetch_blk + 16'd1;
        end else begin
          fetch_off <= fetch_off + 10'd1;
        end
      end else if (xfer) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flash_block_streamer.sv
// Bench for flash_block_streamer: a queue-driven flash controller model, a byte scoreboard
// built from the flash contents, table-driven transfers and hand-written corner sequences.
module tb_flash_block_streamer;

  localparam int BS = 512;

  logic        i_clk, i_rst_n, i_start;
  logic [23:0] i_start_addr;
  logic [15:0] i_num_blocks;
  logic        o_busy, o_done_stb, o_read_stb;
  logic [23:0] o_read_addr;
  logic        i_read_done_stb, i_write_bram_stb;
  logic [9:0]  i_read_bram_addr;
  logic [7:0]  i_read_bram_data;
  logic [7:0]  o_data;
  logic        o_valid, i_ready, o_block_last, o_last;
  logic [1:0]  o_dbg_state;

  flash_block_streamer #(.BLOCK_SIZE(BS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_num_blocks(i_num_blocks), .o_busy(o_busy), .o_done_stb(o_done_stb),
    .o_read_addr(o_read_addr), .o_read_stb(o_read_stb), .i_read_done_stb(i_read_done_stb),
    .i_write_bram_stb(i_write_bram_stb), .i_read_bram_addr(i_read_bram_addr),
    .i_read_bram_data(i_read_bram_data), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_block_last(o_block_last), .o_last(o_last),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- bench state ----------------
  typedef struct {
    logic        wstb;
    logic        done;
    logic [9:0]  addr;
    logic [7:0]  data;
  } fl_ent_t;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] nblk;
    int          pct;
    int          exp_reads;
    int          exp_bytes;
  } vec_t;

  fl_ent_t     fl_q[$];
  logic [9:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  vec_t        vecs[5];

  int n_vec = 0, n_fail = 0;
  int cyc = 0, ready_pct = 100, fill_limit = BS;
  int bytes_seen, rd_count, done_count, fills_done, valid_cycles, last_cyc, done_cyc;
  logic       stall_prev = 1'b0;
  logic [9:0] stall_out = '0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: the whole transfer as a flat list of bytes and block addresses.
  task automatic build_expect(input logic [23:0] start, input logic [15:0] nblk);
    logic [23:0] blk_addr;
    exp_q.delete();
    exp_addr_q.delete();
    for (int b = 0; b < int'(nblk); b++) begin
      blk_addr = start + 24'(b * BS);
      exp_addr_q.push_back(blk_addr);
      for (int off = 0; off < BS; off++)
        exp_q.push_back({flash_byte(blk_addr + 24'(off)), off == BS - 1,
                         (off == BS - 1) && (b == int'(nblk) - 1)});
    end
  endtask

  // Flash controller reply: bytes in order with random gaps and occasional out-of-range writes.
  task automatic schedule_fill(input logic [23:0] base);
    fl_ent_t e;
    e = '{1'b0, 1'b0, 10'd0, 8'd0};
    fl_q.push_back(e);
    fl_q.push_back(e);
    for (int off = 0; off < BS && off < fill_limit; off++) begin
      if ($urandom_range(0, 3) == 0) fl_q.push_back('{1'b0, 1'b0, 10'd0, 8'd0});
      fl_q.push_back('{1'b1, 1'b0, 10'(off), flash_byte(base + 24'(off))});
      if ($urandom_range(0, 15) == 0)
        fl_q.push_back('{1'b1, 1'b0, 10'(BS + off), ~flash_byte(base + 24'(off))});
    end
    if (fill_limit >= BS) fl_q.push_back('{1'b0, 1'b1, 10'd0, 8'd0});
  endtask

  // One clock: drive flash and ready after the rising edge, observe on the falling edge.
  task automatic tick();
    fl_ent_t e;
    logic [9:0] got;
    @(posedge i_clk);
    #1;
    cyc++;
    if (fl_q.size() > 0) begin
      e = fl_q.pop_front();
      i_write_bram_stb = e.wstb;
      i_read_done_stb  = e.done;
      i_read_bram_addr = e.addr;
      i_read_bram_data = e.data;
      if (e.done) fills_done++;
    end else begin
      i_write_bram_stb = 1'b0;
      i_read_done_stb  = 1'b0;
    end
    i_ready = ($urandom_range(0, 99) < ready_pct);
    @(negedge i_clk);
    if (!i_rst_n) begin
      stall_prev = 1'b0;
    end else begin
      got = {o_data, o_block_last, o_last};
      if (stall_prev) check("stall_hold", {o_valid, got}, {1'b1, stall_out});
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0) check("extra_byte", {1'b1, got}, 11'd0);
        else check("stream_byte", got, exp_q.pop_front());
        if (o_last) last_cyc = cyc;
      end
      stall_prev = o_valid && !i_ready;
      stall_out  = got;
      if (o_read_stb) begin
        rd_count++;
        if (exp_addr_q.size() == 0) check("extra_read", {1'b1, o_read_addr}, 25'd0);
        else check("read_addr", o_read_addr, exp_addr_q.pop_front());
        schedule_fill(o_read_addr);
      end
      if (o_done_stb) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic clear_counts();
    bytes_seen = 0; rd_count = 0; done_count = 0; fills_done = 0;
    valid_cycles = 0; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [23:0] addr, input logic [15:0] nblk);
    i_start_addr = addr;
    i_num_blocks = nblk;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
    i_start_addr = 24'($urandom);
    i_num_blocks = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_count == 0 && k < budget) begin
      tick();
      k++;
    end
    check("done_within_budget", done_count != 0, 1'b1);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {o_busy, o_done_stb, o_read_stb, o_read_addr, o_valid, o_data,
                 o_block_last, o_last, o_dbg_state}, '0);
  endtask

  task automatic run_txn(input vec_t v);
    build_expect(v.addr, v.nblk);
    clear_counts();
    ready_pct = v.pct;
    pulse_start(v.addr, v.nblk);
    check("busy_after_start", o_busy, v.nblk != 16'd0);
    check("done_zero_blocks", o_done_stb, v.nblk == 16'd0);
    wait_done(20000);
    check("busy_dropped", o_busy, 1'b0);
    if (v.nblk != 16'd0) check("done_after_last", done_cyc, last_cyc + 1);
    for (int k = 0; k < 4; k++) tick();
    check("done_count", done_count, 1);
    check("read_count", rd_count, v.exp_reads);
    check("byte_count", bytes_seen, v.exp_bytes);
    check("bytes_left", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_start_addr = '0; i_num_blocks = '0;
    i_read_done_stb = 1'b0; i_write_bram_stb = 1'b0; i_read_bram_addr = '0;
    i_read_bram_data = '0; i_ready = 1'b0;
    clear_counts();

    vecs[0] = '{24'h000100, 16'd1, 100, 1, 512};
    vecs[1] = '{24'hFFFE00, 16'd3, 100, 3, 1536};
    vecs[2] = '{24'h000000, 16'd0, 100, 0, 0};
    vecs[3] = '{24'h123456, 16'd4, 50,  4, 2048};
    vecs[4] = '{24'hFFFF00, 16'd2, 30,  2, 1024};

    for (int k = 0; k < 3; k++) tick();
    check_idle_outputs("reset_outputs");
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Consumer stalled: two buffers fill, third request must wait; a start while busy is ignored.
    begin
      int k;
      build_expect(24'h00ABC0, 16'd3);
      clear_counts();
      ready_pct = 0;
      pulse_start(24'h00ABC0, 16'd3);
      k = 0;
      while (fills_done < 2 && k < 5000) begin
        tick();
        k++;
      end
      check("two_fills", fills_done, 2);
      for (int j = 0; j < 40; j++) tick();
      check("no_third_req", rd_count, 2);
      check("valid_held", o_valid, 1'b1);
      pulse_start(24'h000000, 16'd1);
      for (int j = 0; j < 5; j++) tick();
      check("start_ignored_reads", rd_count, 2);
      ready_pct = 100;
      wait_done(20000);
      check("stall_reads", rd_count, 3);
      check("stall_bytes", bytes_seen, 3 * BS);
      check("stall_left", exp_q.size(), 0);
    end

    // Reset in the middle of a block fill, then a stale done strobe from the flash side.
    begin
      build_expect(24'h040000, 16'd2);
      clear_counts();
      ready_pct  = 100;
      fill_limit = 100;
      pulse_start(24'h040000, 16'd2);
      for (int j = 0; j < 160; j++) tick();
      check("partial_read", rd_count, 1);
      i_rst_n = 1'b0;
      fl_q.delete();
      tick();
      tick();
      check_idle_outputs("mid_reset_outputs");
      i_rst_n    = 1'b1;
      fill_limit = BS;
      exp_q.delete();
      exp_addr_q.delete();
      clear_counts();
      fl_q.push_back('{1'b1, 1'b1, 10'd0, 8'hEE});
      fl_q.push_back('{1'b1, 1'b0, 10'd1, 8'hEF});
      for (int j = 0; j < 20; j++) tick();
      check("stale_no_valid", valid_cycles, 0);
      check("stale_no_read", rd_count, 0);
      check_idle_outputs("stale_outputs");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
